mult_unit: RTL and testbench

Iterative 32x32 integer multiplier that responds to the datapath's `start_mult` / `mult_sign` request and returns a 64-bit product in `hi` / `lo`. It sits beside the ALU in the execute stage. The datapath launches an operation with a one-cycle request, and the unit returns the result after a fixed 32-cycle latency. `busy` lets the hazard logic stall `mfhi` / `mflo` and back-to-back multiplies.

---
 rtl/mult_unit_if.sv | 24 ++
 rtl/mult_unit.sv | 107 ++++++++++
 tb/tb_mult_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mult_unit_if.sv
// Request/result bundle between the execute-stage datapath and the iterative multiplier.
// The datapath drives the request side; the multiplier returns the product and its status.
interface mult_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start_mult;
    logic             mult_sign;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start_mult, mult_sign, srca, srcb,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start_mult, mult_sign, srca, srcb,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/mult_unit.sv
// Iterative shift-add WIDTHxWIDTH multiplier with fixed WIDTH-cycle latency.
// Signed operands are reduced to magnitudes at acceptance; the sign is restored on the final step.
module mult_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    mult_unit_if.slave   bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned ACC_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [ACC_W-1:0]   acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic               neg;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               neg_in;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [ACC_W:0]     acc_wide;
    logic [ACC_W-1:0]   acc_next;
    logic [ACC_W-1:0]   result;
    logic               last_step;

    // Operand conditioning and one shift-add step of the datapath
    always_comb begin
        mag_a     = (bus.mult_sign && bus.srca[WIDTH-1]) ? (-bus.srca) : bus.srca;
        mag_b     = (bus.mult_sign && bus.srcb[WIDTH-1]) ? (-bus.srcb) : bus.srcb;
        neg_in    = bus.mult_sign & (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
        addend    = mplier[0] ? mcand : '0;
        sum       = {1'b0, acc[ACC_W-1:WIDTH]} + {1'b0, addend};
        acc_wide  = {sum, acc[WIDTH-1:0]};
        acc_next  = ACC_W'(acc_wide >> 1);
        result    = neg ? (-acc_next) : acc_next;
        last_step = (cnt == CNT_W'(WIDTH - 1));
    end

    // Control FSM, iteration state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start_mult) begin
                        state  <= CALC;
                        busy_q <= 1'b1;
                        mcand  <= mag_a;
                        mplier <= mag_b;
                        neg    <= neg_in;
                        acc    <= '0;
                        cnt    <= '0;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_step) begin
                        {hi_q, lo_q} <= result;
                        state        <= DONE;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_mult_unit.sv
// Scoreboard bench for mult_unit: expected products queued at launch, checked on each done pulse.
module tb_mult_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_unit_if #(.WIDTH(32)) bus ();
    mult_unit #(.WIDTH(32)) dut (.clk(clk), .reset(rst), .bus(bus));

    int          vectors     = 0;
    int          miscompares = 0;
    logic [63:0] sb[$];
    logic [63:0] last_exp    = 64'd0;
    logic [63:0] popped;
    int          busy_run    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa;
        logic [63:0] xb;
        xa = s ? {{32{a[31]}}, a} : {32'd0, a};
        xb = s ? {{32{b[31]}}, b} : {32'd0, b};
        return xa * xb;
    endfunction

    // Result checker: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (rst) begin
            busy_run = 0;
        end else begin
            if (bus.busy) busy_run++;
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 64'(bus.done), 64'(0));
                end else begin
                    popped   = sb.pop_front();
                    last_exp = popped;
                    check("hi", 64'(bus.hi), 64'(popped[63:32]));
                    check("lo", 64'(bus.lo), 64'(popped[31:0]));
                    check("busy_len", 64'(busy_run), 64'(32));
                end
                busy_run = 0;
            end
        end
    end

    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
        bus.start_mult = 1'b1;
        bus.mult_sign  = s;
        bus.srca       = a;
        bus.srcb       = b;
        sb.push_back(model(s, a, b));
        @(posedge clk); #1;
        bus.start_mult = 1'b0;
        bus.srca       = $urandom;
        bus.srcb       = $urandom;
        bus.mult_sign  = 1'($urandom);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 100);
        if (!bus.done) check("timeout", 64'(0), 64'(1));
    endtask

    logic [31:0] vec_a [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] vec_b [4] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001};
    logic        vec_s [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        rst            = 1'b1;
        bus.start_mult = 1'b0;
        bus.mult_sign  = 1'b0;
        bus.srca       = '0;
        bus.srcb       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hi",   64'(bus.hi),   64'(0));
        check("rst_lo",   64'(bus.lo),   64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Unsigned full scale
        @(posedge clk); #1;
        launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done();

        // Signed/unsigned sign handling table
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            launch(vec_s[i], vec_a[i], vec_b[i]);
            wait_done();
        end

        // Start while busy must be ignored
        @(posedge clk); #1;
        launch(1'b0, 32'd7, 32'd6);
        repeat (9) @(posedge clk);
        #1;
        bus.start_mult = 1'b1;
        bus.srca       = 32'd3;
        bus.srcb       = 32'd3;
        @(posedge clk); #1;
        bus.start_mult = 1'b0;
        bus.srca       = $urandom;
        wait_done();

        // Back-to-back: restart in the DONE cycle
        @(posedge clk); #1;
        launch(1'b0, 32'd5, 32'd5);
        wait_done();
        launch(1'b0, 32'h0001_0000, 32'h0001_0000);
        wait_done();

        // Reset mid-operation, with a start asserted alongside reset
        @(posedge clk); #1;
        launch(1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (14) @(posedge clk);
        #1;
        rst            = 1'b1;
        bus.start_mult = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst            = 1'b0;
        bus.start_mult = 1'b0;
        @(negedge clk);
        check("abort_hi",   64'(bus.hi),   64'(0));
        check("abort_lo",   64'(bus.lo),   64'(0));
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_done", 64'(bus.done), 64'(0));
        repeat (40) begin
            @(negedge clk);
            check("post_abort_busy", 64'(bus.busy), 64'(0));
        end
        @(posedge clk); #1;
        launch(1'b0, 32'd2, 32'd3);
        wait_done();

        // Result hold with no further requests
        repeat (100) begin
            @(negedge clk);
            check("hold_result", {bus.hi, bus.lo}, last_exp);
            check("hold_done", 64'(bus.done), 64'(0));
        end

        // Random mix, sometimes restarting in the DONE cycle
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clk); #1;
            end
            launch(1'($urandom), $urandom, $urandom);
            wait_done();
        end

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "watchdog expired");
    end
endmodule
